ib_ram_wr_ctrl: RTL and testbench
=================================

# ib_ram_wr_ctrl

Parametrised write controller for the IB-LUT RAM of a layered decoder's check/variable node units. On each iteration request it fetches the next iteration's IB-map from ROM and bursts it into a multi-page, multi-bank RAM. Completed loads are committed by advancing a write page, so the datapath can read one page while the next is written. It also counts iterations. It sits between the decoding-process top-level control (iteration request/termination) and the IB ROM/RAM datapath.

## Interface
Parameters:
- LOAD_CYCLE, 32: write cycles per load; all banks are written in parallel each cycle.
- ROM_LATENCY, 2: ROM read pipeline depth in cycles; range 1..7.
- PAGE_NUM, 2: number of RAM pages, ping-pong or deeper; at least 1.
- ITER_MAX, 10: iteration limit, used only with the limit feature.

Widths: ADDR_W = max(1, clog2(LOAD_CYCLE)); PAGE_W = max(1, clog2(PAGE_NUM)); ITER_W = clog2(ITER_MAX+1).

Ports:
- write_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- iter_rqst  in  1  level request; its rising edge starts a load.
- iter_termination  in  1  aborts any load and blocks new starts.
- rom_port_fetch  out  1  ROM read-port enable.
- rom_rst  out  1  ROM read-port reset.
- ram_mux_en  out  1  RAM write-data mux selects the ROM path.
- ram_write_en  out  1  RAM write enable, all banks.
- ram_write_addr  out  ADDR_W  RAM write address.
- ram_page_sel  out  PAGE_W  page currently being written.
- iter_update  out  1  iteration update in progress.
- busy  out  2  00 = IDLE, 01 = loading, 10 = FINISH.
- load_done  out  1  one-cycle pulse on normal completion.
- load_abort  out  1  one-cycle pulse on termination abort.
- iter_cnt  out  ITER_W  number of completed loads.
- iter_limit  out  1  iteration limit reached.
- state  out  2  current FSM state.

## Operation
- The FSM has four states: IDLE, ROM_FETCH, RAM_LOAD, FINISH.
- Start condition: rqst_rise = iter_rqst & ~iter_rqst_q, where iter_rqst_q is registered and resets to 0.
- IDLE → ROM_FETCH when rqst_rise & ~iter_termination & ~iter_limit.
- ROM_FETCH lasts exactly ROM_LATENCY cycles, timed by fetch_cnt, then goes to RAM_LOAD.
- RAM_LOAD lasts exactly LOAD_CYCLE cycles:
  - ram_write_addr = 0 .. LOAD_CYCLE-1, one step per cycle.
  - After the last address the FSM goes to FINISH and pulses load_done.
- iter_termination high in ROM_FETCH or RAM_LOAD:
  - next state is FINISH and load_abort pulses;
  - ram_page_sel and iter_cnt do not change.
- FINISH holds while iter_rqst = 1, and goes to IDLE on the first cycle iter_rqst = 0.
- Outputs decoded from state:
  - IDLE: rom_rst = 1; all other strobes 0; busy = 00.
  - ROM_FETCH: rom_port_fetch = 1, iter_update = 1, busy = 01.
  - RAM_LOAD: rom_port_fetch = 1, ram_mux_en = 1, ram_write_en = 1, iter_update = 1, busy = 01.
  - FINISH: rom_rst = 1, busy = 10.
- ram_write_addr is 0 outside RAM_LOAD.
- On load_done:
  - ram_page_sel advances modulo PAGE_NUM; with PAGE_NUM = 1 it stays 0.
  - iter_cnt increments.
- A rising edge of iter_rqst while not in IDLE is ignored and is not queued.
- If iter_termination and rqst_rise are both high in IDLE, termination wins and the FSM stays in IDLE.
- Reset values: state = IDLE, all counters and ram_page_sel = 0, iter_rqst_q = 0. Every output takes its IDLE value: rom_rst = 1, all others 0.
- Reset asserted mid-load aborts with no load_abort pulse.

## Timing
- Cycle numbering: let cycle 0 be the edge at which rqst_rise is sampled.
  - ROM_FETCH occupies cycles 1 .. ROM_LATENCY.
  - RAM_LOAD occupies cycles ROM_LATENCY+1 .. ROM_LATENCY+LOAD_CYCLE.
  - FINISH starts at cycle ROM_LATENCY+LOAD_CYCLE+1. load_done is high in that same cycle, and ram_page_sel and iter_cnt show their new values there.
- All outputs are registered or decoded from the registered state; there are no combinational input-to-output paths.
- Abort latency: iter_termination sampled high at cycle n gives FINISH and load_abort at cycle n+1.
- load_done and load_abort are mutually exclusive, each high for exactly one cycle.

## Configuration
IB_WR_ITER_LIMIT_EN
- Defined:
  - iter_cnt saturates at ITER_MAX.
  - iter_limit is high while iter_cnt == ITER_MAX, which blocks new starts.
  - Reset is the only way to clear it.
- Undefined:
  - iter_limit is tied to 0.
  - iter_cnt wraps modulo 2^ITER_W.
  - ITER_MAX is ignored.

## Structure
- Package ib_ram_wr_pkg holds:
  - the state encoding, 2'b00 IDLE, 2'b01 ROM_FETCH, 2'b10 RAM_LOAD, 2'b11 FINISH;
  - the busy codes;
  - a clog2-min-1 width helper.
- Sub-module ib_wr_cnt: a generic load/clear/terminal-count up-counter, instantiated for fetch_cnt and ram_write_addr.
- The page and iteration counters stay inline.

## Test plan
- Reset then idle, with rst high 3 cycles and iter_rqst = 0 → state = 0, rom_rst = 1, busy = 00, all other outputs 0.
- Nominal load, LOAD_CYCLE = 32, ROM_LATENCY = 2, iter_rqst rising at cycle 0:
  - rom_port_fetch high from cycle 1;
  - ram_write_en high at cycles 3..34 with addresses 0..31;
  - load_done at cycle 35, ram_page_sel 0 → 1, iter_cnt = 1, busy = 10;
  - after iter_rqst drops, IDLE.
- Page wrap, PAGE_NUM = 2: three complete loads → ram_page_sel sequence 1, 0, 1; iter_cnt = 3.
- Abort: iter_termination pulsed in the cycle with ram_write_addr = 10 → next cycle FINISH, load_abort = 1, ram_write_en = 0, page_sel and iter_cnt unchanged.
- Priority and no queuing:
  - iter_rqst held high through the load, then a second rising edge during RAM_LOAD → ignored, only one load_done;
  - simultaneous iter_termination and rising edge in IDLE → no start.
- Limit, with IB_WR_ITER_LIMIT_EN and ITER_MAX = 5:
  - 5 loads → iter_limit = 1, and a 6th request produces no start;
  - without the macro → a 6th load completes and iter_cnt = 6.

Source files
------------

// File: rtl/ib_ram_wr_pkg.sv
// Shared types and helpers for the IB-LUT RAM write controller.
package ib_ram_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ROM_FETCH = 2'b01,
    ST_RAM_LOAD  = 2'b10,
    ST_FINISH    = 2'b11
  } wr_state_e;

  localparam logic [1:0] BUSY_IDLE    = 2'b00;
  localparam logic [1:0] BUSY_LOADING = 2'b01;
  localparam logic [1:0] BUSY_FINISH  = 2'b10;

  // Address width that never collapses to zero bits for tiny depths.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/ib_wr_cnt.sv
// Generic up-counter with clear, load and terminal-count flag; wraps after TERM.
module ib_wr_cnt #(
  parameter int W    = 4,
  parameter int TERM = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == W'(TERM));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = tc_o ? '0 : cnt_q + W'(1);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ib_ram_wr_ctrl.sv
// IB-LUT RAM write controller: ROM fetch, RAM burst, page commit and iteration count.
// Optional feature macro: IB_WR_ITER_LIMIT_EN (saturating iteration limit).
module ib_ram_wr_ctrl
  import ib_ram_wr_pkg::*;
#(
  parameter int LOAD_CYCLE  = 32,
  parameter int ROM_LATENCY = 2,
  parameter int PAGE_NUM    = 2,
  parameter int ITER_MAX    = 10,
  localparam int ADDR_W     = clog2_min1(LOAD_CYCLE),
  localparam int PAGE_W     = clog2_min1(PAGE_NUM),
  localparam int ITER_W     = $clog2(ITER_MAX + 1)
) (
  input  logic              write_clk,
  input  logic              rst,
  input  logic              iter_rqst,
  input  logic              iter_termination,
  output logic              rom_port_fetch,
  output logic              rom_rst,
  output logic              ram_mux_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [PAGE_W-1:0] ram_page_sel,
  output logic              iter_update,
  output logic [1:0]        busy,
  output logic              load_done,
  output logic              load_abort,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              iter_limit,
  output logic [1:0]        state
);

  localparam int FETCH_W = clog2_min1(ROM_LATENCY);

  wr_state_e         state_q, state_d;
  logic              iter_rqst_q;
  logic              rqst_rise;
  logic              fetch_tc, addr_tc;
  logic [FETCH_W-1:0] fetch_cnt;
  logic [PAGE_W-1:0] page_q;
  logic [ITER_W-1:0] iter_cnt_q;
  logic              load_done_q, load_abort_q;
  logic              done_d, abort_d;
  logic              in_load;

  assign rqst_rise = iter_rqst & ~iter_rqst_q;
  assign in_load   = (state_q == ST_ROM_FETCH) || (state_q == ST_RAM_LOAD);
  assign done_d    = (state_q == ST_RAM_LOAD) && addr_tc && !iter_termination;
  assign abort_d   = in_load && iter_termination;

  ib_wr_cnt #(.W(FETCH_W), .TERM(ROM_LATENCY - 1)) u_fetch_cnt (
    .clk        (write_clk),
    .rst        (rst),
    .clr_i      (state_q != ST_ROM_FETCH),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (state_q == ST_ROM_FETCH),
    .cnt_o      (fetch_cnt),
    .tc_o       (fetch_tc)
  );

  // Cleared on the next-state so the address reads 0 in every cycle outside RAM_LOAD.
  ib_wr_cnt #(.W(ADDR_W), .TERM(LOAD_CYCLE - 1)) u_addr_cnt (
    .clk        (write_clk),
    .rst        (rst),
    .clr_i      (state_d != ST_RAM_LOAD),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (state_q == ST_RAM_LOAD),
    .cnt_o      (ram_write_addr),
    .tc_o       (addr_tc)
  );

`ifdef IB_WR_ITER_LIMIT_EN
  assign iter_limit = (iter_cnt_q == ITER_W'(ITER_MAX));
`else
  assign iter_limit = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d        = state_q;
    rom_port_fetch = 1'b0;
    rom_rst        = 1'b0;
    ram_mux_en     = 1'b0;
    ram_write_en   = 1'b0;
    iter_update    = 1'b0;
    busy           = BUSY_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        rom_rst = 1'b1;
        if (rqst_rise && !iter_termination && !iter_limit) state_d = ST_ROM_FETCH;
      end
      ST_ROM_FETCH: begin
        rom_port_fetch = 1'b1;
        iter_update    = 1'b1;
        busy           = BUSY_LOADING;
        if (iter_termination) state_d = ST_FINISH;
        else if (fetch_tc)    state_d = ST_RAM_LOAD;
      end
      ST_RAM_LOAD: begin
        rom_port_fetch = 1'b1;
        ram_mux_en     = 1'b1;
        ram_write_en   = 1'b1;
        iter_update    = 1'b1;
        busy           = BUSY_LOADING;
        if (iter_termination || addr_tc) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        rom_rst = 1'b1;
        busy    = BUSY_FINISH;
        if (!iter_rqst) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge write_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      iter_rqst_q  <= 1'b0;
      page_q       <= '0;
      iter_cnt_q   <= '0;
      load_done_q  <= 1'b0;
      load_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      iter_rqst_q  <= iter_rqst;
      load_done_q  <= done_d;
      load_abort_q <= abort_d;
      if (done_d) begin
        page_q <= (page_q == PAGE_W'(PAGE_NUM - 1)) ? '0 : page_q + PAGE_W'(1);
`ifdef IB_WR_ITER_LIMIT_EN
        if (!iter_limit) iter_cnt_q <= iter_cnt_q + ITER_W'(1);
`else
        iter_cnt_q <= iter_cnt_q + ITER_W'(1);
`endif
      end
    end
  end

  assign ram_page_sel = page_q;
  assign iter_cnt     = iter_cnt_q;
  assign load_done    = load_done_q;
  assign load_abort   = load_abort_q;
  assign state        = state_q;

endmodule

// File: tb/tb_ib_ram_wr_ctrl.sv
// Directed self-checking bench for ib_ram_wr_ctrl (LOAD_CYCLE=32, ROM_LATENCY=2, PAGE_NUM=2, ITER_MAX=5).
module tb_ib_ram_wr_ctrl;

  localparam int LC = 32;
  localparam int RL = 2;

  logic       write_clk = 1'b0;
  logic       rst = 1'b1;
  logic       iter_rqst = 1'b0;
  logic       iter_termination = 1'b0;
  logic       rom_port_fetch, rom_rst, ram_mux_en, ram_write_en;
  logic [4:0] ram_write_addr;
  logic [0:0] ram_page_sel;
  logic       iter_update;
  logic [1:0] busy;
  logic       load_done, load_abort;
  logic [2:0] iter_cnt;
  logic       iter_limit;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  ib_ram_wr_ctrl #(.LOAD_CYCLE(LC), .ROM_LATENCY(RL), .PAGE_NUM(2), .ITER_MAX(5)) dut (
    .write_clk        (write_clk),
    .rst              (rst),
    .iter_rqst        (iter_rqst),
    .iter_termination (iter_termination),
    .rom_port_fetch   (rom_port_fetch),
    .rom_rst          (rom_rst),
    .ram_mux_en       (ram_mux_en),
    .ram_write_en     (ram_write_en),
    .ram_write_addr   (ram_write_addr),
    .ram_page_sel     (ram_page_sel),
    .iter_update      (iter_update),
    .busy             (busy),
    .load_done        (load_done),
    .load_abort       (load_abort),
    .iter_cnt         (iter_cnt),
    .iter_limit       (iter_limit),
    .state            (state)
  );

  always #5 write_clk = ~write_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge write_clk);
  endtask

  // Strobe vector {rom_port_fetch, rom_rst, ram_mux_en, ram_write_en, iter_update, load_done, load_abort}
  function automatic logic [6:0] strobes();
    return {rom_port_fetch, rom_rst, ram_mux_en, ram_write_en, iter_update, load_done, load_abort};
  endfunction

  task automatic full_load(input int exp_page, input int exp_iter);
    iter_rqst = 1'b1;
    step();
    check("fetch1_state", state, 2'd1);
    check("fetch1_strobes", strobes(), 7'b1000100);
    check("fetch1_busy", busy, 2'b01);
    step();
    check("fetch2_state", state, 2'd1);
    for (int i = 0; i < LC; i++) begin
      step();
      check("load_state", state, 2'd2);
      check("load_strobes", strobes(), 7'b1011100);
      check("load_addr", ram_write_addr, i);
    end
    step();
    check("fin_state", state, 2'd3);
    check("fin_strobes", strobes(), 7'b0100010);
    check("fin_busy", busy, 2'b10);
    check("fin_page", ram_page_sel, exp_page);
    check("fin_iter", iter_cnt, exp_iter);
    check("fin_addr", ram_write_addr, 0);
    iter_rqst = 1'b0;
    step();
    check("idle_state", state, 2'd0);
    check("idle_strobes", strobes(), 7'b0100000);
  endtask

  initial begin
    int dones;
    int cyc;

    // Reset held for three cycles with no request.
    repeat (3) step();
    check("rst_state", state, 2'd0);
    check("rst_strobes", strobes(), 7'b0100000);
    check("rst_busy", busy, 2'b00);
    check("rst_addr", ram_write_addr, 0);
    check("rst_page", ram_page_sel, 0);
    check("rst_iter", iter_cnt, 0);
    check("rst_limit", iter_limit, 0);
    rst = 1'b0;
    step();
    check("post_rst_state", state, 2'd0);

    // Three complete loads: page 1,0,1 and count 1,2,3.
    full_load(1, 1);
    full_load(0, 2);
    full_load(1, 3);

    // Termination during RAM_LOAD at address 10.
    iter_rqst = 1'b1;
    repeat (RL + 1) step();
    repeat (10) step();
    check("abort_pre_addr", ram_write_addr, 10);
    iter_termination = 1'b1;
    step();
    check("abort_state", state, 2'd3);
    check("abort_pulse", load_abort, 1);
    check("abort_done", load_done, 0);
    check("abort_wen", ram_write_en, 0);
    check("abort_page", ram_page_sel, 1);
    check("abort_iter", iter_cnt, 3);
    iter_termination = 1'b0;
    iter_rqst = 1'b0;
    step();
    check("abort_idle", state, 2'd0);
    check("abort_pulse_once", load_abort, 0);

    // Second rising edge mid-load is ignored; FINISH holds while request stays high.
    iter_rqst = 1'b1;
    dones = 0;
    cyc = 0;
    repeat (RL + 5) begin step(); dones += int'(load_done); cyc++; end
    iter_rqst = 1'b0;
    step(); dones += int'(load_done); cyc++;
    iter_rqst = 1'b1;
    while (state != 2'd3 && cyc < 100) begin step(); dones += int'(load_done); cyc++; end
    check("noq_reach_finish", state, 2'd3);
    repeat (3) begin step(); dones += int'(load_done); end
    check("noq_hold_finish", state, 2'd3);
    check("noq_one_done", dones, 1);
    check("noq_page", ram_page_sel, 0);
    check("noq_iter", iter_cnt, 4);
    iter_rqst = 1'b0;
    step();
    check("noq_idle", state, 2'd0);
    step();
    check("noq_not_queued", state, 2'd0);

    // Termination and rising edge together in IDLE: no start.
    iter_rqst = 1'b1;
    iter_termination = 1'b1;
    step();
    check("prio_state", state, 2'd0);
    iter_termination = 1'b0;
    step();
    check("prio_no_late_start", state, 2'd0);
    iter_rqst = 1'b0;
    step();

    // Fifth load reaches ITER_MAX; sixth depends on the limit feature.
    full_load(1, 5);
`ifdef IB_WR_ITER_LIMIT_EN
    check("limit_set", iter_limit, 1);
    iter_rqst = 1'b1;
    step();
    check("limit_block", state, 2'd0);
    step();
    check("limit_iter_hold", iter_cnt, 5);
    iter_rqst = 1'b0;
    step();
`else
    check("limit_off", iter_limit, 0);
    full_load(0, 6);
`endif

    // Reset mid-load: no abort pulse, counters cleared.
    iter_rqst = 1'b1;
    repeat (RL + 4) step();
    check("mid_rst_loading", state, 2'd2);
    rst = 1'b1;
    step();
    check("mid_rst_state", state, 2'd0);
    check("mid_rst_strobes", strobes(), 7'b0100000);
    check("mid_rst_iter", iter_cnt, 0);
    check("mid_rst_page", ram_page_sel, 0);
    rst = 1'b0;
    iter_rqst = 1'b0;
    step();
    check("mid_rst_no_abort", load_abort, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
